// File: rtl/rr_outport_aggr_pkg.sv
// Shared constants, mode codes and round-robin helpers for the aggregated
// output-port rewrite stage.
`timescale 1ns/1ps
package rr_outport_aggr_pkg;

    // Module-header ctrl value identifying the IO queue stage header
    localparam logic [7:0]  IO_QUEUE_STAGE_NUM = 8'hff;
    // Bit position of the 16-bit one-hot dst_port field in that header
    localparam int unsigned IOQ_DST_PORT_POS   = 0;

    typedef enum logic [1:0] {
        OUT_AGGR_MODE_PASS = 2'b00,
        OUT_AGGR_MODE_RR   = 2'b01
    } out_aggr_mode_t;

    typedef enum logic {
        WAIT_HDR = 1'b0,
        IN_PKT   = 1'b1
    } aggr_state_t;

    // MAC ports live on the even dst_port bits; collapse them to a 4-bit set
    function automatic logic [3:0] mac_members(input logic [15:0] mask);
        return {mask[6], mask[4], mask[2], mask[0]};
    endfunction

    // Lowest MAC index present in the mask, 0 when the mask has none
    function automatic logic [1:0] first_member(input logic [15:0] mask);
        logic [3:0] m;
        logic [1:0] r;
        logic [1:0] cand;
        logic       found;
        m     = mac_members(mask);
        r     = 2'd0;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = 2'(i);
            if (!found && m[cand]) begin
                r     = cand;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Next MAC index after ptr (wrapping 3->0) present in the mask;
    // a single-member mask returns ptr itself, an empty one leaves ptr alone
    function automatic logic [1:0] next_member(input logic [1:0] ptr,
                                               input logic [15:0] mask);
        logic [3:0] m;
        logic [1:0] r;
        logic [1:0] cand;
        logic       found;
        m     = mac_members(mask);
        r     = ptr;
        found = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = ptr + 2'(i);
            if (!found && m[cand]) begin
                r     = cand;
                found = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_outport_aggr_fifo.sv
// Small first-word-fall-through FIFO: dout always shows the head entry.
// Writes while full are dropped; nearly_full leaves one slot of margin.
`timescale 1ns/1ps
module fallthrough_small_fifo #(
    parameter int unsigned WIDTH          = 72,
    parameter int unsigned MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam int unsigned                DEPTH      = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0]    DEPTH_FULL = (MAX_DEPTH_BITS+1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0]    DEPTH_NEAR = (MAX_DEPTH_BITS+1)'(DEPTH - 1);

    logic [WIDTH-1:0]          r_mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
    logic [MAX_DEPTH_BITS:0]   r_count;
    logic                      w_full;
    logic                      w_push;
    logic                      w_pop;

    assign w_full      = (r_count == DEPTH_FULL);
    assign w_push      = wr_en && !w_full;
    assign w_pop       = rd_en && (r_count != '0);
    assign empty       = (r_count == '0);
    assign nearly_full = (r_count >= DEPTH_NEAR);
    assign dout        = r_mem[r_rd_ptr];

    // Storage array, no reset needed: entries are only read once counted
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; reset flushes the FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rr_outport_aggr.sv
// Output-port aggregation stage: spreads packets addressed to an aggregated
// MAC group round-robin across its members by rewriting the one-hot dst_port
// field of the IO queue module header. Everything else passes untouched.
`timescale 1ns/1ps
module rr_outport_aggr
    import rr_outport_aggr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter logic [15:0] AGGR_PORT_MASK  = 16'h0055,
    parameter int unsigned FIFO_DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic [1:0]            outport_sel,
    output logic                  state,
    output logic                  eop
);

    localparam logic              HAS_MEMBER = |mac_members(AGGR_PORT_MASK);
    localparam logic [1:0]        RR_START   = first_member(AGGR_PORT_MASK);
    localparam logic [CTRL_WIDTH-1:0] IOQ_CTRL = CTRL_WIDTH'(IO_QUEUE_STAGE_NUM);

    logic [CTRL_WIDTH+DATA_WIDTH-1:0] w_fifo_dout;
    logic [DATA_WIDTH-1:0]            w_fifo_data;
    logic [CTRL_WIDTH-1:0]            w_fifo_ctrl;
    logic                             w_fifo_empty;
    logic                             w_fifo_nearly_full;
    logic                             w_pop;
    logic [15:0]                      w_dp;
    logic                             w_rewrite;
    logic [DATA_WIDTH-1:0]            w_out_data;

    aggr_state_t           r_state;
    logic [1:0]            r_rr_ptr;
    logic                  r_eop;
    logic                  r_out_wr;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [CTRL_WIDTH-1:0] r_out_ctrl;

    fallthrough_small_fifo #(
        .WIDTH          (CTRL_WIDTH + DATA_WIDTH),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_in_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         ({in_ctrl, in_data}),
        .wr_en       (in_wr),
        .rd_en       (w_pop),
        .dout        (w_fifo_dout),
        .nearly_full (w_fifo_nearly_full),
        .empty       (w_fifo_empty)
    );

    assign {w_fifo_ctrl, w_fifo_data} = w_fifo_dout;
    assign in_rdy = !w_fifo_nearly_full;
    assign w_pop  = out_rdy && !w_fifo_empty;
    assign w_dp   = w_fifo_data[IOQ_DST_PORT_POS +: 16];

    // Mode is looked at only here, i.e. at the instant the header is popped
    assign w_rewrite = w_pop && (r_state == WAIT_HDR) && (w_fifo_ctrl == IOQ_CTRL)
                    && (outport_sel == OUT_AGGR_MODE_RR)
                    && ((w_dp & AGGR_PORT_MASK) != '0) && HAS_MEMBER;

    // Rewrite mux: swap the group bits for the single currently selected member
    always_comb begin
        w_out_data = w_fifo_data;
        if (w_rewrite) begin
            w_out_data[IOQ_DST_PORT_POS +: 16] =
                (w_dp & ~AGGR_PORT_MASK) | (16'h1 << {r_rr_ptr, 1'b0});
        end
    end

    // Registered output word: presented the cycle after it leaves the FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_wr   <= 1'b0;
            r_out_data <= '0;
            r_out_ctrl <= '0;
        end else begin
            r_out_wr <= w_pop;
            if (w_pop) begin
                r_out_data <= w_out_data;
                r_out_ctrl <= w_fifo_ctrl;
            end
        end
    end

    // Packet framing FSM, end-of-packet pulse and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= WAIT_HDR;
            r_eop    <= 1'b0;
            r_rr_ptr <= RR_START;
        end else begin
            r_eop <= 1'b0;
            if (w_pop) begin
                case (r_state)
                    WAIT_HDR: begin
                        if (w_fifo_ctrl == '0) begin
                            r_state <= IN_PKT;
                        end
                    end
                    IN_PKT: begin
                        if (w_fifo_ctrl != '0) begin
                            r_state <= WAIT_HDR;
                            r_eop   <= 1'b1;
                        end
                    end
                endcase
            end
            if (w_rewrite) begin
                r_rr_ptr <= next_member(r_rr_ptr, AGGR_PORT_MASK);
            end
        end
    end

    assign out_wr   = r_out_wr;
    assign out_data = r_out_data;
    assign out_ctrl = r_out_ctrl;
    assign state    = r_state;
    assign eop      = r_eop;

endmodule

// File: tb/tb_rr_outport_aggr.sv
// Bench for rr_outport_aggr: two instances (group mask 0x0055 and 0x0014)
// receive identical traffic; a per-instance reference model predicts each
// output word into a queue that a negedge monitor drains and compares.
`timescale 1ns/1ps
module tb_rr_outport_aggr;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  c;
        logic        e;
        logic        s;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        out_rdy;
    logic [1:0]  outport_sel;

    logic        rdy_a, wr_a, state_a, eop_a;
    logic [63:0] data_a;
    logic [7:0]  ctrl_a;
    logic        rdy_b, wr_b, state_b, eop_b;
    logic [63:0] data_b;
    logic [7:0]  ctrl_b;

    int          checks;
    int          passes;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [15:0] seen_a[$];
    logic [15:0] seen_b[$];
    int          eop_cnt_a;
    bit          rand_rdy;

    // reference model state: member list of MAC indices and rotating position
    logic [15:0] m_mask[2];
    int          m_mem[2][4];
    int          m_n[2];
    int          m_k[2];
    bit          m_in_pkt[2];

    rr_outport_aggr #(
        .DATA_WIDTH      (64),
        .CTRL_WIDTH      (8),
        .AGGR_PORT_MASK  (16'h0055),
        .FIFO_DEPTH_BITS (2)
    ) u_dut_a (
        .clk (clk), .reset (reset),
        .in_data (in_data), .in_ctrl (in_ctrl), .in_wr (in_wr), .in_rdy (rdy_a),
        .out_data (data_a), .out_ctrl (ctrl_a), .out_wr (wr_a), .out_rdy (out_rdy),
        .outport_sel (outport_sel), .state (state_a), .eop (eop_a)
    );

    rr_outport_aggr #(
        .DATA_WIDTH      (64),
        .CTRL_WIDTH      (8),
        .AGGR_PORT_MASK  (16'h0014),
        .FIFO_DEPTH_BITS (2)
    ) u_dut_b (
        .clk (clk), .reset (reset),
        .in_data (in_data), .in_ctrl (in_ctrl), .in_wr (in_wr), .in_rdy (rdy_b),
        .out_data (data_b), .out_ctrl (ctrl_b), .out_wr (wr_b), .out_rdy (out_rdy),
        .outport_sel (outport_sel), .state (state_b), .eop (eop_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic model_init(input int p, input logic [15:0] mask);
        m_mask[p]   = mask;
        m_n[p]      = 0;
        m_k[p]      = 0;
        m_in_pkt[p] = 0;
        for (int i = 0; i < 4; i++) begin
            if (mask[2*i]) begin
                m_mem[p][m_n[p]] = i;
                m_n[p]++;
            end
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        for (int p = 0; p < 2; p++) begin
            m_k[p]      = 0;
            m_in_pkt[p] = 0;
        end
    endtask

    task automatic model_push(input int p, input logic [63:0] d, input logic [7:0] c);
        exp_t        x;
        logic [15:0] dp;
        x.d = d;
        x.c = c;
        x.e = 1'b0;
        if (!m_in_pkt[p]) begin
            if (c == 8'hff && outport_sel == 2'b01) begin
                dp = d[15:0];
                if ((dp & m_mask[p]) != 16'h0 && m_n[p] > 0) begin
                    x.d[15:0] = (dp & ~m_mask[p]) | 16'(1 << (2 * m_mem[p][m_k[p]]));
                    m_k[p] = (m_k[p] + 1) % m_n[p];
                end
            end
            if (c == 8'h00) m_in_pkt[p] = 1;
        end else if (c != 8'h00) begin
            x.e = 1'b1;
            m_in_pkt[p] = 0;
        end
        x.s = m_in_pkt[p];
        if (p == 0) qa.push_back(x);
        else        qb.push_back(x);
    endtask

    task automatic send_word(input logic [63:0] d, input logic [7:0] c);
        int t;
        t = 0;
        while (!(rdy_a && rdy_b) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!(rdy_a && rdy_b)) begin
            chk("in_rdy_timeout", {63'b0, rdy_a && rdy_b}, 64'd1);
        end else begin
            in_data = d;
            in_ctrl = c;
            in_wr   = 1'b1;
            model_push(0, d, c);
            model_push(1, d, c);
            @(posedge clk); #1;
            in_wr = 1'b0;
        end
    endtask

    task automatic send_pkt(input logic [15:0] dp, input int npay, input bit xhdr);
        logic [63:0] w;
        w = {$urandom, $urandom};
        w[15:0] = dp;
        send_word(w, 8'hff);
        if (xhdr) send_word({$urandom, $urandom}, 8'($urandom_range(1, 254)));
        repeat (npay) send_word({$urandom, $urandom}, 8'h00);
        send_word({$urandom, $urandom}, 8'(1 << $urandom_range(0, 7)));
    endtask

    task automatic drain(input string name);
        int t;
        out_rdy = 1'b1;
        t = 0;
        while ((qa.size() != 0 || qb.size() != 0) && t < 500) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_drain_a"}, 64'(qa.size()), 64'd0);
        chk({name, "_drain_b"}, 64'(qb.size()), 64'd0);
    endtask

    task automatic mon_port(input int p, input logic wr, input logic [63:0] d,
                            input logic [7:0] c, input logic e, input logic s);
        exp_t  x;
        string tag;
        bit    have;
        tag  = (p == 0) ? "A" : "B";
        have = (p == 0) ? (qa.size() != 0) : (qb.size() != 0);
        if (wr) begin
            if (!have) begin
                chk({tag, "_unexpected_out_wr"}, {63'b0, wr}, 64'd0);
            end else begin
                if (p == 0) x = qa.pop_front();
                else        x = qb.pop_front();
                chk({tag, "_out_data"}, d, x.d);
                chk({tag, "_out_ctrl"}, {56'b0, c}, {56'b0, x.c});
                chk({tag, "_eop"}, {63'b0, e}, {63'b0, x.e});
                chk({tag, "_state"}, {63'b0, s}, {63'b0, x.s});
                if (x.c == 8'hff) begin
                    if (p == 0) seen_a.push_back(d[15:0]);
                    else        seen_b.push_back(d[15:0]);
                end
                if (p == 0 && e) eop_cnt_a++;
            end
        end else if (e) begin
            chk({tag, "_eop_without_out_wr"}, {63'b0, e}, 64'd0);
        end
    endtask

    // Monitor: compares every presented output word against the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            mon_port(0, wr_a, data_a, ctrl_a, eop_a, state_a);
            mon_port(1, wr_b, data_b, ctrl_b, eop_b, state_b);
        end
    end

    // Random downstream back-pressure while enabled
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) out_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passes, checks);
        $fatal(1);
    end

    initial begin
        checks = 0; passes = 0; eop_cnt_a = 0;
        reset = 1'b1; in_wr = 1'b0; in_data = '0; in_ctrl = '0;
        out_rdy = 1'b1; outport_sel = 2'b00; rand_rdy = 1'b0;
        model_init(0, 16'h0055);
        model_init(1, 16'h0014);

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_wr", {63'b0, wr_a}, 64'd0);
        chk("rst_out_data", data_a, 64'd0);
        chk("rst_out_ctrl", {56'b0, ctrl_a}, 64'd0);
        chk("rst_eop", {63'b0, eop_a}, 64'd0);
        chk("rst_state", {63'b0, state_a}, 64'd0);
        chk("rst_in_rdy", {63'b0, rdy_a}, 64'd1);
        chk("rst_out_wr_b", {63'b0, wr_b}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: pass-through mode, header + 3 words
        outport_sel = 2'b00;
        eop_cnt_a = 0;
        send_pkt(16'h0004, 2, 0);
        drain("t1");
        chk("t1_eop_count", 64'(eop_cnt_a), 64'd1);

        // 2: round-robin across all four MACs
        outport_sel = 2'b01;
        seen_a.delete();
        repeat (5) send_pkt(16'h0001, 1, 0);
        drain("t2");
        chk("t2_hdr_count", 64'(seen_a.size()), 64'd5);
        chk("t2_dp0", {48'b0, seen_a[0]}, 64'h0001);
        chk("t2_dp1", {48'b0, seen_a[1]}, 64'h0004);
        chk("t2_dp2", {48'b0, seen_a[2]}, 64'h0010);
        chk("t2_dp3", {48'b0, seen_a[3]}, 64'h0040);
        chk("t2_dp4", {48'b0, seen_a[4]}, 64'h0001);

        // 3: CPU-only destination on the 0x0014 group leaves pointer alone
        seen_b.delete();
        send_pkt(16'h0102, 2, 1);
        send_pkt(16'h0004, 1, 0);
        send_pkt(16'h0004, 1, 0);
        drain("t3");
        chk("t3_b_dp0", {48'b0, seen_b[0]}, 64'h0102);
        chk("t3_b_dp1", {48'b0, seen_b[1]}, 64'h0004);
        chk("t3_b_dp2", {48'b0, seen_b[2]}, 64'h0010);

        // 4: non-group bits survive the rewrite
        seen_a.delete();
        seen_b.delete();
        send_pkt(16'h0205, 1, 0);
        drain("t4");
        chk("t4_a_dp", {48'b0, seen_a[0]}, 64'h0240);
        chk("t4_b_dp", {48'b0, seen_b[0]}, 64'h0205);

        // 5: downstream stall for 10 clocks while streaming
        out_rdy = 1'b0;
        fork
            send_pkt(16'h0010, 6, 1);
            begin
                repeat (10) @(posedge clk);
                #1;
                chk("t5_in_rdy_low", {63'b0, rdy_a}, 64'd0);
                out_rdy = 1'b1;
            end
        join
        drain("t5");

        // 6: reset in the middle of a packet
        send_word({48'h0, 16'h0001}, 8'hff);
        send_word({$urandom, $urandom}, 8'h00);
        send_word({$urandom, $urandom}, 8'h00);
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("t6_out_wr", {63'b0, wr_a}, 64'd0);
        chk("t6_state", {63'b0, state_a}, 64'd0);
        chk("t6_eop", {63'b0, eop_a}, 64'd0);
        chk("t6_in_rdy", {63'b0, rdy_a}, 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        seen_a.delete();
        seen_b.delete();
        send_pkt(16'h0015, 2, 0);
        drain("t6");
        chk("t6_a_dp", {48'b0, seen_a[0]}, 64'h0001);
        chk("t6_b_dp", {48'b0, seen_b[0]}, 64'h0005);

        // random batches: mode fixed within a batch, random back-pressure
        for (int b = 0; b < 8; b++) begin
            outport_sel = 2'($urandom_range(0, 3));
            rand_rdy = 1'b1;
            for (int k = 0; k < 5; k++) begin
                logic [15:0] dp;
                dp = 16'($urandom) & (($urandom_range(0, 2) == 0) ? 16'hffaa : 16'hffff);
                send_pkt(dp, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
            end
            rand_rdy = 1'b0;
            drain("rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
